// File: rtl/result_ascii_formatter.sv
`default_nettype none
// ============================================================================
//  Module   : result_ascii_formatter
//  Purpose  : Buffers signed accelerator result words in a small FIFO and
//             prints each one as signed decimal ASCII, one character per
//             valid/ready handshake. A space follows every value; a newline
//             replaces the space after every PER_LINE-th value.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   1       clock
//    rst          in   1       synchronous active-high reset
//    read_data    in   DATA_W  two's-complement result word
//    read_valid   in   1       read_data valid this cycle (no backpressure)
//    in_full      out  1       FIFO full; a word presented now is dropped
//    overflow     out  1       sticky drop indicator, cleared only by rst
//    print_char   out  8       ASCII character
//    print_valid  out  1       print_char valid
//    print_ready  in   1       sink accepts print_char this cycle
//    busy         out  1       FIFO non-empty or a value is in flight
// ============================================================================
module result_ascii_formatter #(
   parameter int DATA_W     = 18,
   parameter int FIFO_DEPTH = 8,
   parameter int PER_LINE   = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] read_data,
   input  logic              read_valid,
   output logic              in_full,
   output logic              overflow,
   output logic [7:0]        print_char,
   output logic              print_valid,
   input  logic              print_ready,
   output logic              busy
);

   // Number of decimal digits needed for the largest magnitude, 2^(DATA_W-1).
   function automatic int calc_digits(input int width);
      longint v;
      int     n;
      v = longint'(1) << (width - 1);
      n = 0;
      while (v > 0) begin
         n++;
         v = v / 10;
      end
      return n;
   endfunction

   localparam int c_ndig   = calc_digits(DATA_W);
   localparam int c_aw     = $clog2(FIFO_DEPTH);
   localparam int c_idx_w  = (c_ndig > 1) ? $clog2(c_ndig) : 1;
   localparam int c_line_w = (PER_LINE > 1) ? $clog2(PER_LINE) : 1;
   localparam int c_cnt_w  = $clog2(DATA_W + 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_CONVERT = 3'd1,
      S_SIGN    = 3'd2,
      S_DIGITS  = 3'd3,
      S_SEP     = 3'd4
   } state_t;

   // ------------------------------------------------------------------------
   // Input FIFO. Pointers carry one extra bit so full and empty differ.
   // ------------------------------------------------------------------------
   logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
   logic [c_aw:0]     r_wr_ptr;
   logic [c_aw:0]     r_rd_ptr;
   logic              r_overflow;
   logic              w_empty;
   logic              w_full;
   logic              w_push;
   logic              w_pop;
   logic [DATA_W-1:0] w_head;

   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                    (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
   // A full FIFO rejects the push even if a pop frees a slot this cycle.
   assign w_push  = read_valid && !w_full;
   assign w_head  = r_mem[r_rd_ptr[c_aw-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + (c_aw + 1)'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + (c_aw + 1)'(1);
         end
         if (read_valid && w_full) begin
            r_overflow <= 1'b1;
         end
      end
   end

   // Storage has no reset; only the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr[c_aw-1:0]] <= read_data;
      end
   end

   // ------------------------------------------------------------------------
   // Conversion datapath
   // ------------------------------------------------------------------------
   state_t                   r_state;
   state_t                   w_state_nxt;
   logic                     r_neg;
   // DATA_W bits suffice for the magnitude: 2^(DATA_W-1) is representable
   // as an unsigned DATA_W-bit number, so the most negative input is exact.
   logic [DATA_W-1:0]        r_mag;
   logic [c_ndig-1:0][3:0]   r_bcd;
   logic [c_cnt_w-1:0]       r_cnt;
   logic [c_idx_w-1:0]       r_dig_idx;
   logic [c_line_w-1:0]      r_line;

   logic [DATA_W-1:0]        w_head_mag;
   logic [c_ndig-1:0][3:0]   w_bcd_adj;
   logic [c_ndig*4-1:0]      w_adj_flat;
   logic [c_idx_w-1:0]       w_first_nz;
   logic [3:0]               w_cur_digit;
   logic                     w_cnt_done;
   logic                     w_last_on_line;

   assign w_head_mag     = w_head[DATA_W-1] ? (~w_head + DATA_W'(1)) : w_head;
   assign w_cnt_done     = (r_cnt == c_cnt_w'(DATA_W));
   assign w_cur_digit    = r_bcd[r_dig_idx];
   assign w_last_on_line = (r_line == c_line_w'(PER_LINE - 1));
   assign w_adj_flat     = w_bcd_adj;

   // Double-dabble correction: any digit >= 5 gets +3 before the shift.
   always_comb begin
      w_bcd_adj = r_bcd;
      for (int i = 0; i < c_ndig; i++) begin
         if (r_bcd[i] >= 4'd5) begin
            w_bcd_adj[i] = r_bcd[i] + 4'd3;
         end
      end
   end

   // Highest non-zero digit; stays 0 for value zero so a single '0' prints.
   always_comb begin
      w_first_nz = '0;
      for (int i = 0; i < c_ndig; i++) begin
         if (r_bcd[i] != 4'd0) begin
            w_first_nz = c_idx_w'(i);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_neg     <= 1'b0;
         r_mag     <= '0;
         r_bcd     <= '0;
         r_cnt     <= '0;
         r_dig_idx <= '0;
         r_line    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_pop) begin
                  r_neg <= w_head[DATA_W-1];
                  r_mag <= w_head_mag;
                  r_bcd <= '0;
                  r_cnt <= '0;
               end
            end
            S_CONVERT: begin
               if (!w_cnt_done) begin
                  r_bcd <= {w_adj_flat[c_ndig*4-2:0], r_mag[DATA_W-1]};
                  r_mag <= {r_mag[DATA_W-2:0], 1'b0};
                  r_cnt <= r_cnt + c_cnt_w'(1);
               end else begin
                  r_dig_idx <= w_first_nz;
               end
            end
            S_DIGITS: begin
               if (print_ready && (r_dig_idx != '0)) begin
                  r_dig_idx <= r_dig_idx - c_idx_w'(1);
               end
            end
            S_SEP: begin
               if (print_ready) begin
                  r_line <= w_last_on_line ? '0 : (r_line + c_line_w'(1));
               end
            end
            default: begin
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Control FSM
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Outputs depend only on registered state, so print_char is stable for
   // as long as the sink stalls.
   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      print_valid = 1'b0;
      print_char  = 8'h00;
      case (r_state)
         S_IDLE: begin
            if (!w_empty) begin
               w_pop       = 1'b1;
               w_state_nxt = S_CONVERT;
            end
         end
         S_CONVERT: begin
            // One extra cycle after the last shift selects the first digit.
            if (w_cnt_done) begin
               w_state_nxt = r_neg ? S_SIGN : S_DIGITS;
            end
         end
         S_SIGN: begin
            print_valid = 1'b1;
            print_char  = 8'h2D;
            if (print_ready) begin
               w_state_nxt = S_DIGITS;
            end
         end
         S_DIGITS: begin
            print_valid = 1'b1;
            print_char  = 8'h30 + {4'h0, w_cur_digit};
            if (print_ready && (r_dig_idx == '0)) begin
               w_state_nxt = S_SEP;
            end
         end
         S_SEP: begin
            print_valid = 1'b1;
            print_char  = w_last_on_line ? 8'h0A : 8'h20;
            if (print_ready) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign in_full  = w_full;
   assign overflow = r_overflow;
   assign busy     = !w_empty || (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_result_ascii_formatter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_result_ascii_formatter
//  Purpose  : Directed self-checking bench. A decimal-print model builds the
//             expected character stream; a compare process checks every
//             presented character against it; literal strings pin the model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_result_ascii_formatter;

   localparam int DATA_W   = 18;
   localparam int PER_LINE = 8;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [DATA_W-1:0] read_data = '0;
   logic              read_valid = 1'b0;
   logic              in_full;
   logic              overflow;
   logic [7:0]        print_char;
   logic              print_valid;
   logic              print_ready = 1'b0;
   logic              busy;

   int         total = 0;
   int         bad   = 0;
   logic [7:0] exp_q[$];
   logic [7:0] cap_q[$];
   int         model_line = 0;
   bit         prev_hold = 1'b0;

   result_ascii_formatter #(
      .DATA_W    (DATA_W),
      .FIFO_DEPTH(8),
      .PER_LINE  (PER_LINE)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .read_data  (read_data),
      .read_valid (read_valid),
      .in_full    (in_full),
      .overflow   (overflow),
      .print_char (print_char),
      .print_valid(print_valid),
      .print_ready(print_ready),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Decimal text of v followed by its separator, tracking line position.
   function automatic void model_add(input int v);
      int a;
      int n;
      int d[12];
      a = (v < 0) ? -v : v;
      if (v < 0) exp_q.push_back(8'h2D);
      if (a == 0) begin
         exp_q.push_back(8'h30);
      end else begin
         n = 0;
         while (a > 0) begin
            d[n] = a % 10;
            a    = a / 10;
            n++;
         end
         for (int i = n - 1; i >= 0; i--) exp_q.push_back(8'(8'h30 + d[i]));
      end
      model_line++;
      if (model_line == PER_LINE) begin
         exp_q.push_back(8'h0A);
         model_line = 0;
      end else begin
         exp_q.push_back(8'h20);
      end
   endfunction

   // Checks every cycle the outputs are meaningful.
   always @(negedge clk) begin
      if (rst) begin
         prev_hold = 1'b0;
      end else begin
         if (prev_hold) check("hold_valid", int'(print_valid), 1);
         if (print_valid) begin
            if (exp_q.size() == 0) begin
               check("spurious_valid", int'(print_valid), 0);
            end else begin
               check("char", int'(print_char), int'(exp_q[0]));
               if (print_ready) begin
                  cap_q.push_back(print_char);
                  void'(exp_q.pop_front());
               end
            end
         end
         prev_hold = print_valid && !print_ready;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int v);
      read_valid = 1'b1;
      read_data  = DATA_W'(v);
      tick();
      read_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst        = 1'b1;
      read_valid = 1'b0;
      exp_q.delete();
      model_line = 0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || busy) && n < 1000) begin
         tick();
         n++;
      end
      check({name, "_drain_timeout"}, int'(n < 1000), 1);
   endtask

   task automatic wait_valid(input string name);
      int n;
      n = 0;
      while (!print_valid && n < 100) begin
         tick();
         n++;
      end
      check({name, "_valid_timeout"}, int'(n < 100), 1);
   endtask

   task automatic check_cap(input string name, input string s);
      check({name, "_len"}, cap_q.size(), s.len());
      for (int i = 0; i < s.len() && i < cap_q.size(); i++) begin
         check(name, int'(cap_q[i]), int'(s[i]));
      end
   endtask

   initial begin
      int vals[10];

      // Reset state
      tick();
      tick();
      check("rst_print_char", int'(print_char), 0);
      check("rst_print_valid", int'(print_valid), 0);
      check("rst_in_full", int'(in_full), 0);
      check("rst_overflow", int'(overflow), 0);
      check("rst_busy", int'(busy), 0);
      rst = 1'b0;
      tick();

      // Zero: latency and busy fall
      print_ready = 1'b1;
      cap_q.delete();
      model_add(0);
      push(0);
      check("zero_busy_after_push", int'(busy), 1);
      for (int k = 1; k <= 19; k++) begin
         tick();
         check("zero_latency_low", int'(print_valid), 0);
      end
      tick();
      check("zero_latency_high", int'(print_valid), 1);
      tick();
      check("zero_busy_mid", int'(busy), 1);
      tick();
      check("zero_busy_fall", int'(busy), 0);
      drain("zero");
      check_cap("zero_text", "0 ");

      // Extremes
      do_reset();
      cap_q.delete();
      model_add(-131072);
      model_add(131071);
      push(-131072);
      push(131071);
      drain("extremes");
      check_cap("extremes_text", "-131072 131071 ");

      // Line wrap
      do_reset();
      cap_q.delete();
      for (int i = 0; i < 9; i++) begin
         model_add(5);
         push(5);
      end
      drain("line");
      check_cap("line_text", "5 5 5 5 5 5 5 5\n5 ");

      // Backpressure hold
      do_reset();
      cap_q.delete();
      print_ready = 1'b0;
      model_add(42);
      push(42);
      wait_valid("hold");
      for (int k = 0; k < 10; k++) begin
         check("hold_char_lit", int'(print_char), 8'h34);
         check("hold_valid_lit", int'(print_valid), 1);
         tick();
      end
      print_ready = 1'b1;
      drain("hold");
      check_cap("hold_text", "42 ");

      // Overflow: ten back-to-back words while stalled, last one dropped
      do_reset();
      cap_q.delete();
      print_ready = 1'b0;
      vals = '{1, -2, 30, -400, 5000, -60000, 70000, -99999, 123, 777};
      for (int i = 0; i < 9; i++) model_add(vals[i]);
      for (int i = 0; i < 10; i++) push(vals[i]);
      check("ovf_in_full", int'(in_full), 1);
      check("ovf_overflow", int'(overflow), 1);
      print_ready = 1'b1;
      drain("ovf");
      check_cap("ovf_text", "1 -2 30 -400 5000 -60000 70000 -99999\n123 ");
      check("ovf_sticky", int'(overflow), 1);

      // Reset in the middle of DIGITS with three words queued
      cap_q.delete();
      print_ready = 1'b0;
      model_add(123456);
      model_add(7);
      model_add(8);
      model_add(9);
      push(123456);
      push(7);
      push(8);
      push(9);
      wait_valid("midrst");
      print_ready = 1'b1;
      tick();
      tick();
      rst = 1'b1;
      exp_q.delete();
      model_line = 0;
      tick();
      check("midrst_valid", int'(print_valid), 0);
      check("midrst_busy", int'(busy), 0);
      check("midrst_overflow", int'(overflow), 0);
      check("midrst_in_full", int'(in_full), 0);
      rst = 1'b0;
      for (int k = 0; k < 60; k++) tick();
      check("midrst_quiet_valid", int'(print_valid), 0);
      check("midrst_quiet_busy", int'(busy), 0);
      check_cap("midrst_text", "12");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
